// File: rtl/seq_mul_32.sv
// seq_mul_32: iterative 32x32 shift-add multiplier for the EX stage.
// One add per clock through a 32-bit carry-lookahead adder, 32 iterations,
// 64-bit product with a start/busy/done handshake for the hazard unit.
// Optional feature macro: MUL_SIGNED_EN (signed operands when sign_mode=1).

// 32-bit adder built from 4-bit carry-lookahead groups.
module cla_32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [32:0] w_c;

  assign w_g = x & y;
  assign w_p = x ^ y;

  // Carry lookahead inside each 4-bit group, group carry passed to the next group.
  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    for (int k = 0; k < 8; k++) begin
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+4] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
    end
  end

  assign s    = w_p ^ w_c[31:0];
  assign cout = w_c[32];
endmodule

// State table
//   state  | meaning
//   S_IDLE | waiting for start, P holds the last result
//   S_BUSY | one shift-add iteration per clock, 32 iterations
//   S_DONE | done pulse, P valid; start here is accepted back-to-back
module seq_mul_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               sign_mode,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_p;
  logic [WIDTH-1:0]     w_y;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic [WIDTH-1:0]     w_hi_nxt;
  logic [WIDTH-1:0]     w_lo_nxt;
  logic [2*WIDTH-1:0]   w_prod_nxt;
  logic [2*WIDTH-1:0]   w_final;
  logic [WIDTH-1:0]     w_mcand_in;
  logic [WIDTH-1:0]     w_mplier_in;
  logic                 w_last;

  assign w_last = (r_cnt == CNT_W'(WIDTH-1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Add the multiplicand when the current multiplier bit is set, then shift right.
  assign w_y = r_lo[0] ? r_mcand : '0;

  cla_32 u_add (
    .x    (r_hi),
    .y    (w_y),
    .cin  (1'b0),
    .s    (w_sum),
    .cout (w_cout)
  );

  assign w_hi_nxt   = {w_cout, w_sum[WIDTH-1:1]};
  assign w_lo_nxt   = {w_sum[0], r_lo[WIDTH-1:1]};
  assign w_prod_nxt = {w_hi_nxt, w_lo_nxt};

`ifdef MUL_SIGNED_EN
  logic w_neg_in;
  logic r_neg;

  // Signed requests iterate on magnitudes; the sign is reapplied at the end.
  assign w_mcand_in  = (sign_mode && A[WIDTH-1]) ? -A : A;
  assign w_mplier_in = (sign_mode && B[WIDTH-1]) ? -B : B;
  assign w_neg_in    = sign_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
  assign w_final     = r_neg ? -w_prod_nxt : w_prod_nxt;

  // Result sign, captured with the operands.
  always_ff @(posedge clk) begin
    if (rst)           r_neg <= 1'b0;
    else if (w_accept) r_neg <= w_neg_in;
  end
`else
  logic w_unused_sign_mode;

  assign w_unused_sign_mode = sign_mode;
  assign w_mcand_in         = A;
  assign w_mplier_in        = B;
  assign w_final            = w_prod_nxt;
`endif

  // Operand capture, iteration and result update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else if (w_accept) begin
      r_mcand <= w_mcand_in;
      r_hi    <= '0;
      r_lo    <= w_mplier_in;
      r_cnt   <= '0;
    end else if (r_state == S_BUSY) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) r_p <= w_final;
    end
  end

  assign P = r_p;
endmodule

// File: tb/tb_seq_mul_32.sv
// Directed bench for seq_mul_32: reset, basic, max operands, busy protection,
// reset mid-run and signed/unsigned handling of sign_mode.
module tb_seq_mul_32;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        sign_mode;
  logic        busy;
  logic        done;
  logic [63:0] P;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_mul_32 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .sign_mode (sign_mode),
    .busy      (busy),
    .done      (done),
    .P         (P)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
  endtask

  // Start in the current cycle (cycle 0), check busy over cycles 1..32,
  // done and P in cycle 33, and P held in cycle 34.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sm, input logic [63:0] exp);
    A = a; B = b; sign_mode = sm; start = 1'b1;
    step();
    start = 1'b0;
    A = ~a; B = ~b;
    for (int c = 1; c <= 32; c++) begin
      chk({tag, " busy"}, {63'd0, busy}, 64'd1);
      chk({tag, " done_early"}, {63'd0, done}, 64'd0);
      step();
    end
    chk({tag, " done"}, {63'd0, done}, 64'd1);
    chk({tag, " busy_off"}, {63'd0, busy}, 64'd0);
    chk({tag, " P"}, P, exp);
    step();
    chk({tag, " done_pulse"}, {63'd0, done}, 64'd0);
    chk({tag, " P_held"}, P, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; sign_mode = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset P", P, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("idle no done", {63'd0, done}, 64'd0);
    end

    run_op("basic", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_op("zero", 32'd0, 32'hDEAD_BEEF, 1'b0, 64'd0);
    run_op("shift", 32'h1234_5678, 32'h10, 1'b0, 64'h0000_0001_2345_6780);

    // Busy protection: a start in cycle 10 is ignored, then back-to-back from DONE.
    A = 32'd7; B = 32'd9; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      chk("prot busy", {63'd0, busy}, 64'd1);
      if (c == 10) begin
        start = 1'b1; A = 32'd2; B = 32'd2;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk("prot done", {63'd0, done}, 64'd1);
    chk("prot P", P, 64'h3F);
    A = 32'd2; B = 32'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b busy", {63'd0, busy}, 64'd1);
    chk("b2b done", {63'd0, done}, 64'd0);
    chk("b2b P held", P, 64'h3F);
    for (int c = 35; c <= 66; c++) step();
    chk("b2b done66", {63'd0, done}, 64'd1);
    chk("b2b P", P, 64'd4);
    step();

    // Reset mid-run: rst asserted in cycle 10 aborts the operation.
    A = 32'h1234; B = 32'h10; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 10; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort P", P, 64'd0);
    for (int c = 11; c <= 40; c++) begin
      chk("abort no done", {63'd0, done}, 64'd0);
      step();
    end

    run_op("unsigned_mode0", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1);
`ifdef MUL_SIGNED_EN
    run_op("signed", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("signed_negneg", 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 64'h0000_0000_0000_000F);
`else
    run_op("signed", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'h0000_0004_FFFF_FFF1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
